data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Responder for the single-cycle core's data-memory port.
- Decodes the core's address, write data and write strobe (ALUResult, WriteData, MemWrite) and returns ReadData within the same cycle.
- Backs a word-addressed data RAM plus a small MMIO block: GPIO output register and a prescaled machine timer with compare/pending flag.
- Sits at top level beside the core and the instruction memory.

Parameters:
- RAM_DEPTH, 64, number of 32-bit words in data RAM; power of 2.
- TICK_DIV, 1, core clocks per timer increment; must be >= 1.
- MMIO_BASE, 32'h8000_0000, base address of the MMIO window (16 bytes).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Addr  input  32  byte address from core (ALUResult).
- WriteData  input  32  store data.
- MemWrite  input  1  write strobe, one word per cycle.
- ReadData  output  32  combinational read data.
- GpioOut  output  32  GPIO output register.
- TimerIrq  output  1  timer pending flag.
- MemErr  output  1  sticky access-error flag; present only with DMEM_ERR_EN.

Behaviour:
- Word access only; Addr[1:0] ignored for decode.
- RAM region: Addr < 4*RAM_DEPTH, index = Addr[log2(RAM_DEPTH)+1:2].
- MMIO region: Addr[31:4] == MMIO_BASE[31:4]. All other addresses are unmapped.
- Read is combinational from current state. A write lands on the rising edge and is visible to a read the next cycle. There is no read-during-write bypass.
- RAM contents are not cleared by reset.
- MMIO map, offset Addr[3:2]:
  - 0: GPIO_OUT, RW.
  - 1: MTIME, RW; a write loads the counter.
  - 2: MTIMECMP, RW.
  - 3: STATUS; bit0 = pending (read), write 1 to bit0 clears it, other bits read 0.
- Unmapped read returns 32'h0. Unmapped write is dropped.
- Reset values: GpioOut=0, MTIME=0, MTIMECMP=32'hFFFF_FFFF, pending=0, prescaler=0, MemErr=0. ReadData follows decode.
- Prescaler counts 0..TICK_DIV-1. When it is at TICK_DIV-1 it wraps to 0 and MTIME increments. MTIME wraps FFFF_FFFF -> 0.
- A write to MTIME that cycle takes priority over the increment and resets the prescaler to 0.
- Pending sets on any cycle where registered MTIME == MTIMECMP. It is sticky until a W1C.
- Simultaneous set and W1C: set wins.
- A MTIMECMP write takes effect for the compare on the next cycle.
- TimerIrq = pending, registered, with no combinational path from Addr.
- Reset asserted mid-count clears the timer state immediately (async). Writes in that cycle are dropped.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined: MemErr port exists. It sets on the clock edge after any access with MemWrite=1 and Addr[1:0]!=0, or any MemWrite=1 to an unmapped address. It is sticky and cleared only by reset. The offending write is still dropped if unmapped, or performed word-aligned if misaligned-but-mapped.
- Undefined: no MemErr port and no error logic; behaviour otherwise identical.

Decomposition:
- Package dmem_pkg:
  - MMIO offset constants (OFF_GPIO, OFF_MTIME, OFF_MTIMECMP, OFF_STATUS).
  - Reset constants (MTIMECMP_RST).
  - Region-select enum (SEL_RAM, SEL_MMIO, SEL_NONE).
- One sub-module dmem_timer: owns prescaler, MTIME, MTIMECMP and pending, with write-enable/select inputs and read-data output.
- Address decode, RAM array and GPIO live in the top.

Test Plan:
1. Reset, then read 0x8000_0004 / 0x8000_0008 / 0x8000_000C -> 0, FFFF_FFFF, 0; GpioOut=0, TimerIrq=0.
2. Write 32'hDEADBEEF to 0x10, read 0x10 next cycle -> DEADBEEF; read 0x14 -> RAM value unaffected; read 0x4000_0000 -> 0.
3. TICK_DIV=4: write MTIME=0; after 8 clocks MTIME reads 2. Write MTIMECMP=3; TimerIrq rises the cycle after MTIME reaches 3. Write 1 to STATUS -> TimerIrq=0 next cycle and stays 0 after MTIME passes 3.
4. MTIME=FFFF_FFFE, TICK_DIV=1: reads FFFF_FFFF then 0 on successive cycles. A write to MTIME in the same cycle as the tick loads the written value.
5. Hold MTIME==MTIMECMP while writing 1 to STATUS -> pending stays 1. Assert reset mid-count -> TimerIrq and MTIME 0 immediately, asynchronously.
6. DMEM_ERR_EN defined: write to 0x0000_0012 -> word at 0x10 updated, MemErr=1 next edge and sticky. Write to 0x4000_0000 -> MemErr=1, no RAM change. Macro undefined: build has no MemErr port.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared constants and types for the data-memory responder.
//   - MMIO word offsets inside the 16-byte MMIO window (Addr[3:2])
//   - timer compare reset value
//   - region-select enum produced by the address decoder
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam logic [1:0] OFF_GPIO     = 2'd0;
  localparam logic [1:0] OFF_MTIME    = 2'd1;
  localparam logic [1:0] OFF_MTIMECMP = 2'd2;
  localparam logic [1:0] OFF_STATUS   = 2'd3;

  // Compare starts at all-ones so a freshly reset timer does not fire early.
  localparam logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_MMIO,
    SEL_NONE
  } sel_e;

endpackage

// File: rtl/dmem_timer.sv
// -----------------------------------------------------------------------------
// dmem_timer
// Prescaled machine timer: prescaler, MTIME, MTIMECMP and a sticky pending flag.
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   we           write strobe already qualified to the timer's MMIO words
//   off          MMIO word offset (Addr[3:2])
//   wdata        store data
//   rdata        combinational read data for MTIME / MTIMECMP / STATUS
//   irq          registered pending flag
// -----------------------------------------------------------------------------
module dmem_timer
  import dmem_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int unsigned      PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic [31:0]   mtime;
  logic [31:0]   mtimecmp;
  logic          pending;

  logic we_mtime;
  logic we_cmp;
  logic we_status;

  assign we_mtime  = we && (off == OFF_MTIME);
  assign we_cmp    = we && (off == OFF_MTIMECMP);
  assign we_status = we && (off == OFF_STATUS);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      mtime <= '0;
    end else if (we_mtime) begin
      // A software load wins over a tick landing on the same edge.
      mtime <= wdata;
      presc <= '0;
    end else if (presc == PRESC_MAX) begin
      presc <= '0;
      mtime <= mtime + 32'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtimecmp <= MTIMECMP_RST;
    end else if (we_cmp) begin
      mtimecmp <= wdata;
    end
  end

  // Compare uses the registered MTIME/MTIMECMP; a match re-asserts every cycle
  // it holds, so a W1C on a matching cycle loses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (mtime == mtimecmp) begin
      pending <= 1'b1;
    end else if (we_status && wdata[0]) begin
      pending <= 1'b0;
    end
  end

  assign irq = pending;

  // NOTE: the output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata = '0;
    case (off)
      OFF_MTIME:    rdata = mtime;
      OFF_MTIMECMP: rdata = mtimecmp;
      OFF_STATUS:   rdata = {31'b0, pending};
      default:      rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Data-memory port responder for the single-cycle core. Decodes the byte
// address into a word RAM, a 16-byte MMIO window (GPIO + machine timer) or
// unmapped space, returns read data combinationally and commits writes on the
// rising edge (no read-during-write bypass).
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   Addr         byte address (ALUResult); Addr[1:0] ignored for decode
//   WriteData    store data
//   MemWrite     one-word write strobe
//   ReadData     combinational read data, 0 for unmapped addresses
//   GpioOut      GPIO output register
//   TimerIrq     timer pending flag (registered)
//   MemErr       sticky access-error flag, only when DMEM_ERR_EN is defined
// Build option: define DMEM_ERR_EN to add the MemErr port and its logic.
// -----------------------------------------------------------------------------
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_DEPTH = 64,
  parameter int unsigned TICK_DIV  = 1,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic [31:0] GpioOut,
  output logic        TimerIrq
`ifdef DMEM_ERR_EN
  ,
  output logic        MemErr
`endif
);

  localparam int unsigned AW        = $clog2(RAM_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_DEPTH);

  sel_e          sel;
  logic [AW-1:0] ram_idx;
  logic [1:0]    off;
  logic          ram_we;
  logic          mmio_we;
  logic          timer_we;
  logic [31:0]   timer_rdata;

  logic [31:0] ram [RAM_DEPTH];

  always_comb begin
    if (Addr < RAM_BYTES) begin
      sel = SEL_RAM;
    end else if (Addr[31:4] == MMIO_BASE[31:4]) begin
      sel = SEL_MMIO;
    end else begin
      sel = SEL_NONE;
    end
  end

  assign ram_idx  = Addr[AW+1:2];
  assign off      = Addr[3:2];
  assign ram_we   = MemWrite && (sel == SEL_RAM);
  assign mmio_we  = MemWrite && (sel == SEL_MMIO);
  assign timer_we = mmio_we && (off != OFF_GPIO);

  // NOTE: the RAM array has no reset; clearing it would force it into flops.
  // Writes are only suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && ram_we) begin
      ram[ram_idx] <= WriteData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      GpioOut <= '0;
    end else if (mmio_we && (off == OFF_GPIO)) begin
      GpioOut <= WriteData;
    end
  end

  dmem_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .we    (timer_we),
    .off   (off),
    .wdata (WriteData),
    .rdata (timer_rdata),
    .irq   (TimerIrq)
  );

  always_comb begin
    ReadData = '0;
    case (sel)
      SEL_RAM:  ReadData = ram[ram_idx];
      SEL_MMIO: ReadData = (off == OFF_GPIO) ? GpioOut : timer_rdata;
      default:  ReadData = '0;
    endcase
  end

`ifdef DMEM_ERR_EN
  // Misaligned stores still land word-aligned; unmapped stores are dropped.
  // Either one latches the error until reset.
  logic err_set;
  assign err_set = MemWrite && ((Addr[1:0] != 2'b00) || (sel == SEL_NONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MemErr <= 1'b0;
    end else if (err_set) begin
      MemErr <= 1'b1;
    end
  end
`else
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^Addr[1:0];
`endif

endmodule
